// File: rtl/p_reg_n_pkg.sv
`default_nettype none
// ============================================================================
// Module   : p_reg_n_pkg
// Brief    : Pipeline register constants: bubble encoding and stage widths.
// Revision : 1.0
// ============================================================================
package p_reg_n_pkg;

    typedef enum logic [1:0] {
        STAGE_IF_ID  = 2'd0,
        STAGE_ID_EX  = 2'd1,
        STAGE_EX_MEM = 2'd2,
        STAGE_MEM_WB = 2'd3
    } stageSel_e;

    localparam int IF_ID_W  = 64;
    localparam int ID_EX_W  = 150;
    localparam int EX_MEM_W = 107;
    localparam int MEM_WB_W = 71;

    // Bubble is all-zeros; downstream control decodes zero as a NOP.
    localparam logic BUBBLE_BIT = 1'b0;

endpackage : p_reg_n_pkg
`default_nettype wire

// File: rtl/p_reg_n.sv
`default_nettype none
// ============================================================================
// Module   : p_reg_n
// Brief    : Width-parameterised pipeline stage register with stall and flush.
// Revision : 1.0
// ============================================================================
module p_reg_n
    import p_reg_n_pkg::*;
#(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         hold,
    input  logic         kill,
    input  logic         rst,
    input  logic [n-1:0] dataIn,
    output logic [n-1:0] dataOut
);

    // Flush outranks stall so a killed slot never survives a hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dataOut <= {n{BUBBLE_BIT}};
        end else if (kill) begin
            dataOut <= {n{BUBBLE_BIT}};
        end else if (!hold) begin
            dataOut <= dataIn;
        end
    end

endmodule : p_reg_n
`default_nettype wire

// File: tb/tb_p_reg_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_p_reg_n
// Brief    : Self-checking bench for p_reg_n at widths 6, 1 and 32.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_p_reg_n;

    logic        clk = 1'b0;
    logic        hold, kill, rst;
    logic [5:0]  d6,  q6;
    logic        d1,  q1;
    logic [31:0] d32, q32;

    logic [5:0]  m6;
    logic        m1;
    logic [31:0] m32;

    int compared   = 0;
    int mismatched = 0;

    always #2 clk = ~clk;

    p_reg_n #(.n(6))  dut6  (.clk(clk), .hold(hold), .kill(kill), .rst(rst), .dataIn(d6),  .dataOut(q6));
    p_reg_n #(.n(1))  dut1  (.clk(clk), .hold(hold), .kill(kill), .rst(rst), .dataIn(d1),  .dataOut(q1));
    p_reg_n #(.n(32)) dut32 (.clk(clk), .hold(hold), .kill(kill), .rst(rst), .dataIn(d32), .dataOut(q32));

    always @(posedge clk) begin
        assert (!$isunknown(hold) && !$isunknown(kill))
            else $error("FAIL xcheck hold=%b kill=%b must be known", hold, kill);
    end

    task automatic check(input string tag);
        compared++;
        assert (q6 === m6) else begin
            mismatched++;
            $error("FAIL %s n=6 observed=%0d expected=%0d", tag, q6, m6);
        end
        compared++;
        assert (q1 === m1) else begin
            mismatched++;
            $error("FAIL %s n=1 observed=%0d expected=%0d", tag, q1, m1);
        end
        compared++;
        assert (q32 === m32) else begin
            mismatched++;
            $error("FAIL %s n=32 observed=%h expected=%h", tag, q32, m32);
        end
    endtask

    // Reference: a stage register either empties, freezes or takes the new bundle.
    task automatic edgeStep(input string tag);
        @(posedge clk);
        if (!rst || kill) begin
            m6 = '0; m1 = 1'b0; m32 = '0;
        end else if (!hold) begin
            m6 = d6; m1 = d1; m32 = d32;
        end
        #1;
        check(tag);
    endtask

    task automatic asyncReset(input string tag);
        rst = 1'b0;
        #0.5;
        m6 = '0; m1 = 1'b0; m32 = '0;
        check(tag);
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        hold = 1'b0; kill = 1'b0; rst = 1'b1;
        d6 = 6'd42; d1 = 1'b1; d32 = 32'hFFFF_FFFF;
        m6 = 'x; m1 = 'x; m32 = 'x;

        #1 rst = 1'b0;
        #0.5;
        m6 = '0; m1 = 1'b0; m32 = '0;
        check("reset_async");
        edgeStep("reset_across_edge");
        rst = 1'b1;
        edgeStep("reset_release");

        hold = 1'b1; d6 = 6'd9; d1 = 1'b0; d32 = 32'h1234_5678;
        edgeStep("hold");
        hold = 1'b0; d6 = 6'd8; d1 = 1'b1; d32 = 32'hFFFF_FFFF;
        edgeStep("release");

        kill = 1'b1;
        edgeStep("kill_1");
        edgeStep("kill_2");
        kill = 1'b0;
        edgeStep("kill_drop");

        // Input activity between edges must not leak to the output.
        d6 = 6'd5; d1 = 1'b0; d32 = 32'h0;
        #1 check("between_edges");
        d6 = 6'd8; d1 = 1'b1; d32 = 32'hFFFF_FFFF;

        hold = 1'b1; kill = 1'b1;
        edgeStep("kill_over_hold");
        kill = 1'b0;
        edgeStep("hold_after_kill");

        hold = 1'b0; d6 = 6'd42;
        edgeStep("load_42");
        hold = 1'b1; d6 = 6'd17;
        edgeStep("hold_42");
        asyncReset("reset_in_hold");
        hold = 1'b0; d6 = 6'd63; d1 = 1'b1; d32 = 32'hFFFF_FFFF;
        edgeStep("after_reset_63");

        kill = 1'b1;
        asyncReset("reset_in_kill");
        edgeStep("kill_after_reset");
        kill = 1'b0;

        for (int i = 0; i < 300; i++) begin
            hold = ($urandom_range(0, 3) == 0);
            kill = ($urandom_range(0, 5) == 0);
            d6   = 6'($urandom);
            d1   = 1'($urandom);
            d32  = $urandom;
            if ($urandom_range(0, 29) == 0) asyncReset("rand_reset");
            edgeStep("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_p_reg_n
`default_nettype wire
